// File: rtl/reminder_set_ctrl.sv
// Reminder set controller: a button-driven editor for four hour/minute
// reminder slots. It walks through slot select, hour and minute fields,
// commits the edited time into the slot, and abandons the edit after a
// configurable number of cycles without a button press.
module reminder_set_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Enter_p,
  input  logic       Up_p,
  input  logic       Down_p,
  input  logic       Cancel_p,
  input  logic [1:0] Rd_slot,
  output logic [4:0] Rd_hour,
  output logic [5:0] Rd_min,
  output logic       Edit_active,
  output logic [1:0] Field,
  output logic [1:0] Slot_sel,
  output logic [4:0] Hour_val,
  output logic [5:0] Min_val,
  output logic       Wr_p,
  output logic       Timeout_p
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL    = 3'd1,
    ST_HOUR   = 3'd2,
    ST_MIN    = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_reg, state_next;
  logic [1:0]  slot_reg, slot_next;
  logic [4:0]  hour_reg, hour_next;
  logic [5:0]  min_reg, min_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        tmo_reg, tmo_next;
  logic        wr_en;

  logic [4:0]  hour_mem [4];
  logic [5:0]  min_mem  [4];

  // Only the highest-priority pulse of a cycle is acted on.
  logic do_cancel, do_enter, do_up, do_down, any_pulse;
  assign do_cancel = Cancel_p;
  assign do_enter  = Enter_p & ~Cancel_p;
  assign do_up     = Up_p & ~Enter_p & ~Cancel_p;
  assign do_down   = Down_p & ~Up_p & ~Enter_p & ~Cancel_p;
  assign any_pulse = do_cancel | do_enter | do_up | do_down;

  // State register; an illegal encoding falls through to Idle via the default branch.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Edit datapath registers: slot, hour, minute, idle counter and timeout pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      slot_reg <= '0;
      hour_reg <= '0;
      min_reg  <= '0;
      cnt_reg  <= '0;
      tmo_reg  <= 1'b0;
    end else begin
      slot_reg <= slot_next;
      hour_reg <= hour_next;
      min_reg  <= min_next;
      cnt_reg  <= cnt_next;
      tmo_reg  <= tmo_next;
    end
  end

  // Next-state, field edits and idle-timeout handling.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    hour_next  = hour_reg;
    min_next   = min_reg;
    cnt_next   = cnt_reg;
    tmo_next   = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (do_enter) begin
          state_next = ST_SEL;
          slot_next  = 2'd0;
        end
      end
      ST_SEL, ST_HOUR, ST_MIN: begin
        if (any_pulse) begin
          cnt_next = '0;
        end else if (cnt_reg >= TO_LAST) begin
          // Abandon the edit; storage is left untouched.
          state_next = ST_IDLE;
          tmo_next   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
        if (do_cancel) begin
          state_next = ST_IDLE;
        end else if (state_reg == ST_SEL) begin
          if (do_enter) begin
            state_next = ST_HOUR;
            hour_next  = hour_mem[slot_reg];
            min_next   = min_mem[slot_reg];
          end else if (do_up) begin
            slot_next = slot_reg + 2'd1;
          end else if (do_down) begin
            slot_next = slot_reg - 2'd1;
          end
        end else if (state_reg == ST_HOUR) begin
          if (do_enter) begin
            state_next = ST_MIN;
          end else if (do_up) begin
            hour_next = (hour_reg >= 5'd23) ? 5'd0 : hour_reg + 5'd1;
          end else if (do_down) begin
            hour_next = (hour_reg == 5'd0) ? 5'd23 : hour_reg - 5'd1;
          end
        end else begin
          if (do_enter) begin
            state_next = ST_COMMIT;
          end else if (do_up) begin
            min_next = (min_reg >= 6'd59) ? 6'd0 : min_reg + 6'd1;
          end else if (do_down) begin
            min_next = (min_reg == 6'd0) ? 6'd59 : min_reg - 6'd1;
          end
        end
      end
      ST_COMMIT: begin
        wr_en      = 1'b1;
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // One storage register pair per slot, written at the edge that ends Commit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          hour_mem[gi] <= '0;
          min_mem[gi]  <= '0;
        end else if (wr_en && (slot_reg == 2'(gi))) begin
          hour_mem[gi] <= hour_reg;
          min_mem[gi]  <= min_reg;
        end
      end
    end
  endgenerate

  assign Rd_hour     = hour_mem[Rd_slot];
  assign Rd_min      = min_mem[Rd_slot];
  assign Slot_sel    = slot_reg;
  assign Hour_val    = hour_reg;
  assign Min_val     = min_reg;
  assign Timeout_p   = tmo_reg;
  assign Wr_p        = (state_reg == ST_COMMIT);
  assign Edit_active = (state_reg == ST_SEL) || (state_reg == ST_HOUR) ||
                       (state_reg == ST_MIN) || (state_reg == ST_COMMIT);
  assign Field       = (state_reg == ST_SEL)  ? 2'd1 :
                       (state_reg == ST_HOUR) ? 2'd2 :
                       (state_reg == ST_MIN)  ? 2'd3 : 2'd0;

endmodule

// File: tb/tb_reminder_set_ctrl.sv
// Directed bench for reminder_set_ctrl with a short timeout (8 cycles).
module tb_reminder_set_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Enter_p = 1'b0, Up_p = 1'b0, Down_p = 1'b0, Cancel_p = 1'b0;
  logic [1:0] Rd_slot = 2'd0;
  logic [4:0] Rd_hour;
  logic [5:0] Rd_min;
  logic       Edit_active;
  logic [1:0] Field;
  logic [1:0] Slot_sel;
  logic [4:0] Hour_val;
  logic [5:0] Min_val;
  logic       Wr_p;
  logic       Timeout_p;

  int checks = 0;
  int failures = 0;

  reminder_set_ctrl #(.TIMEOUT_CYC(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .Enter_p(Enter_p), .Up_p(Up_p), .Down_p(Down_p), .Cancel_p(Cancel_p),
    .Rd_slot(Rd_slot), .Rd_hour(Rd_hour), .Rd_min(Rd_min),
    .Edit_active(Edit_active), .Field(Field), .Slot_sel(Slot_sel),
    .Hour_val(Hour_val), .Min_val(Min_val), .Wr_p(Wr_p), .Timeout_p(Timeout_p)
  );

  always #5 Clk = ~Clk;

  // Packed view {Edit_active, Field, Slot_sel, Hour_val, Min_val, Wr_p, Timeout_p}.
  logic [17:0] obs;
  assign obs = {Edit_active, Field, Slot_sel, Hour_val, Min_val, Wr_p, Timeout_p};

  function automatic logic [17:0] st(input logic ea, input logic [1:0] f, input logic [1:0] s,
                                     input logic [4:0] h, input logic [5:0] m,
                                     input logic w, input logic t);
    return {ea, f, s, h, m, w, t};
  endfunction

  // One clock with the given pulses held across the rising edge; returns at edge+1.
  task automatic cycle(input logic e, input logic u, input logic d, input logic c);
    Enter_p = e; Up_p = u; Down_p = d; Cancel_p = c;
    @(posedge Clk);
    #1;
    Enter_p = 1'b0; Up_p = 1'b0; Down_p = 1'b0; Cancel_p = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (obs !== 18'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 18'h0);
    end
    for (int i = 0; i < 4; i++) begin
      Rd_slot = 2'(i);
      #1;
      checks++;
      if ({Rd_hour, Rd_min} !== 11'h0) begin
        failures++;
        $display("FAIL reset_slot%0d got=%0d:%0d exp=0:0", i, Rd_hour, Rd_min);
      end
    end
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    $display("tx reset done obs=%h", obs);
  endtask

  task automatic test_idle_ignore;
    logic [2:0] pat [3];
    pat[0] = 3'b100; pat[1] = 3'b010; pat[2] = 3'b001;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, pat[i][2], pat[i][1], pat[i][0]);
      $display("tx idle_ignore pat=%b obs=%h", pat[i], obs);
      checks++;
      if (obs !== 18'h0) begin
        failures++;
        $display("FAIL idle_ignore_%0d got=%h exp=%h", i, obs, 18'h0);
      end
    end
  endtask

  task automatic test_basic;
    logic [17:0] exp;
    cycle(1, 0, 0, 0);
    exp = st(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL basic_enter got=%h exp=%h", obs, exp); end
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    exp = st(1, 1, 2, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL basic_slot2 got=%h exp=%h", obs, exp); end
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0);
    exp = st(1, 2, 2, 7, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL basic_hour7 got=%h exp=%h", obs, exp); end
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    exp = st(1, 3, 2, 7, 59, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL basic_min59 got=%h exp=%h", obs, exp); end
    Rd_slot = 2'd2;
    cycle(1, 0, 0, 0);
    exp = st(1, 0, 2, 7, 59, 1, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL basic_commit got=%h exp=%h", obs, exp); end
    checks++;
    if ({Rd_hour, Rd_min} !== 11'h0) begin
      failures++;
      $display("FAIL basic_rd_during_wr got=%0d:%0d exp=0:0", Rd_hour, Rd_min);
    end
    cycle(0, 0, 0, 0);
    exp = st(0, 0, 2, 7, 59, 0, 0);
    $display("tx basic commit slot2 obs=%h rd=%0d:%0d", obs, Rd_hour, Rd_min);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL basic_after got=%h exp=%h", obs, exp); end
    checks++;
    if ({Rd_hour, Rd_min} !== {5'd7, 6'd59}) begin
      failures++;
      $display("FAIL basic_readback got=%0d:%0d exp=7:59", Rd_hour, Rd_min);
    end
  endtask

  task automatic test_wrap;
    logic [17:0] exp;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    exp = st(1, 1, 3, 7, 59, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL wrap_slot got=%h exp=%h", obs, exp); end
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    exp = st(1, 2, 3, 23, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL wrap_hour_down got=%h exp=%h", obs, exp); end
    cycle(0, 1, 0, 0);
    exp = st(1, 2, 3, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL wrap_hour_up got=%h exp=%h", obs, exp); end
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    exp = st(1, 3, 3, 0, 59, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL wrap_min_down got=%h exp=%h", obs, exp); end
    cycle(0, 1, 0, 0);
    exp = st(1, 3, 3, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL wrap_min_up got=%h exp=%h", obs, exp); end
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    exp = st(0, 0, 3, 0, 59, 0, 0);
    Rd_slot = 2'd3;
    #1;
    $display("tx wrap cancel obs=%h", obs);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL wrap_cancel got=%h exp=%h", obs, exp); end
    checks++;
    if ({Rd_hour, Rd_min} !== 11'h0) begin
      failures++;
      $display("FAIL wrap_no_store got=%0d:%0d exp=0:0", Rd_hour, Rd_min);
    end
  endtask

  task automatic test_same_cycle;
    logic [17:0] exp;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    exp = st(1, 2, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL same_enter_up got=%h exp=%h", obs, exp); end
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    exp = st(1, 3, 1, 0, 1, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL same_up_down got=%h exp=%h", obs, exp); end
    cycle(1, 0, 0, 1);
    exp = st(0, 0, 1, 0, 1, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL same_cancel_enter got=%h exp=%h", obs, exp); end
    cycle(0, 0, 0, 0);
    Rd_slot = 2'd1;
    #1;
    $display("tx same_cycle obs=%h", obs);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL same_no_wr got=%h exp=%h", obs, exp); end
    checks++;
    if ({Rd_hour, Rd_min} !== 11'h0) begin
      failures++;
      $display("FAIL same_no_store got=%0d:%0d exp=0:0", Rd_hour, Rd_min);
    end
  endtask

  task automatic test_timeout;
    logic [17:0] exp;
    int bad;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    exp = st(1, 2, 2, 7, 59, 0, 0);
    bad = 0;
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 0, 0);
      if (obs !== exp) bad = i;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL timeout_early got=%h exp=%h at=%0d", obs, exp, bad); end
    cycle(0, 0, 0, 0);
    exp = st(0, 0, 2, 7, 59, 0, 1);
    $display("tx timeout fired obs=%h", obs);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL timeout_fire got=%h exp=%h", obs, exp); end
    cycle(0, 0, 0, 0);
    exp = st(0, 0, 2, 7, 59, 0, 0);
    Rd_slot = 2'd2;
    #1;
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL timeout_one_cycle got=%h exp=%h", obs, exp); end
    checks++;
    if ({Rd_hour, Rd_min} !== {5'd7, 6'd59}) begin
      failures++;
      $display("FAIL timeout_storage got=%0d:%0d exp=7:59", Rd_hour, Rd_min);
    end
    // Pulse in the last cycle before expiry restarts the count.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    exp = st(1, 2, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL timeout_pulse_wins got=%h exp=%h", obs, exp); end
    bad = 0;
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 0, 0);
      if (obs !== exp) bad = i;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL timeout_restart got=%h exp=%h at=%0d", obs, exp, bad); end
    cycle(0, 0, 0, 0);
    exp = st(0, 0, 0, 1, 0, 0, 1);
    $display("tx timeout restart obs=%h", obs);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL timeout_refire got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_reset_mid;
    logic [17:0] exp;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    exp = st(1, 0, 1, 12, 30, 1, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL mid_commit got=%h exp=%h", obs, exp); end
    cycle(0, 0, 0, 0);
    Rd_slot = 2'd1;
    #1;
    checks++;
    if ({Rd_hour, Rd_min} !== {5'd12, 6'd30}) begin
      failures++;
      $display("FAIL mid_stored got=%0d:%0d exp=12:30", Rd_hour, Rd_min);
    end
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    exp = st(1, 3, 1, 12, 30, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL mid_setmin got=%h exp=%h", obs, exp); end
    #2;
    Rst = 1'b0;
    #1;
    $display("tx reset_mid obs=%h rd=%0d:%0d", obs, Rd_hour, Rd_min);
    checks++;
    if (obs !== 18'h0) begin failures++; $display("FAIL mid_async_out got=%h exp=%h", obs, 18'h0); end
    checks++;
    if ({Rd_hour, Rd_min} !== 11'h0) begin
      failures++;
      $display("FAIL mid_async_slot got=%0d:%0d exp=0:0", Rd_hour, Rd_min);
    end
    #2;
    Rst = 1'b1;
    cycle(0, 1, 0, 0);
    checks++;
    if (obs !== 18'h0) begin failures++; $display("FAIL mid_from_idle got=%h exp=%h", obs, 18'h0); end
    cycle(1, 0, 0, 0);
    exp = st(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL mid_reenter got=%h exp=%h", obs, exp); end
  endtask

  initial begin
    test_reset;
    test_idle_ignore;
    test_basic;
    test_wrap;
    test_same_cycle;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
